// File: rtl/gpio_irq_pkg.sv
// Shared register-window constants for the GPIO interrupt port.
// Offsets are word indices taken from Adr_in[4:2].
package gpio_irq_pkg;

    localparam int unsigned WIN_BYTES = 32;
    localparam int unsigned WIN_LSB   = 5;

    localparam logic [2:0] OFS_OUT  = 3'd0;
    localparam logic [2:0] OFS_DIR  = 3'd1;
    localparam logic [2:0] OFS_IN   = 3'd2;
    localparam logic [2:0] OFS_RISE = 3'd3;
    localparam logic [2:0] OFS_FALL = 3'd4;
    localparam logic [2:0] OFS_STAT = 3'd5;
    localparam logic [2:0] OFS_SET  = 3'd6;
    localparam logic [2:0] OFS_CLR  = 3'd7;

    function automatic logic win_hit(input logic [31:0] adr, input logic [31:0] base);
        return adr[31:WIN_LSB] == base[31:WIN_LSB];
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bit input synchronizer followed by one history flop; flags rising and
// falling transitions seen at the synchronizer output.
module gpio_sync_edge #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]             r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pins};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_hist;
    assign o_fall = ~o_sync & r_hist;

endmodule

// File: rtl/gpio_irq_port.sv
// GPIO port with output/direction registers, synchronized inputs and
// per-pin edge interrupts collected in a write-one-to-clear STATUS register.
module gpio_irq_port
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Adr_in,
    input  logic             WE,
    input  logic [31:0]      Data_in,
    output logic [31:0]      Data_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic             r_irq;

    logic [WIDTH-1:0] w_out_d;
    logic [WIDTH-1:0] w_dir_d;
    logic [WIDTH-1:0] w_rise_en_d;
    logic [WIDTH-1:0] w_fall_en_d;
    logic [WIDTH-1:0] w_status_d;
    logic [WIDTH-1:0] w_stat_clr;

    logic             w_hit;
    logic             w_wr;
    logic [2:0]       w_ofs;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_evt;
    logic             w_unused;

    assign w_hit    = win_hit(Adr_in, BASE_ADR);
    assign w_ofs    = Adr_in[4:2];
    assign w_wr     = WE & w_hit;
    assign w_wdata  = Data_in[WIDTH-1:0];
    assign w_unused = ^{Adr_in[1:0], Data_in};

    gpio_sync_edge #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_pins  (gpio_in),
        .o_sync  (w_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_evt = (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_comb begin
        w_out_d     = r_out;
        w_dir_d     = r_dir;
        w_rise_en_d = r_rise_en;
        w_fall_en_d = r_fall_en;
        w_stat_clr  = '0;
        if (w_wr) begin
            unique case (w_ofs)
                OFS_OUT:  w_out_d     = w_wdata;
                OFS_DIR:  w_dir_d     = w_wdata;
                OFS_RISE: w_rise_en_d = w_wdata;
                OFS_FALL: w_fall_en_d = w_wdata;
                OFS_STAT: w_stat_clr  = w_wdata;
                OFS_SET:  w_out_d     = r_out | w_wdata;
                OFS_CLR:  w_out_d     = r_out & ~w_wdata;
                default:  w_out_d     = r_out;
            endcase
        end
        // New events override a concurrent clear on the same bit.
        w_status_d = (r_status & ~w_stat_clr) | w_evt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_out     <= w_out_d;
            r_dir     <= w_dir_d;
            r_rise_en <= w_rise_en_d;
            r_fall_en <= w_fall_en_d;
            r_status  <= w_status_d;
            r_irq     <= |w_status_d;
        end
    end

    always_comb begin
        Data_out = 32'h0;
        if (w_hit) begin
            unique case (w_ofs)
                OFS_OUT:  Data_out = 32'(r_out);
                OFS_DIR:  Data_out = 32'(r_dir);
                OFS_IN:   Data_out = 32'(w_sync);
                OFS_RISE: Data_out = 32'(r_rise_en);
                OFS_FALL: Data_out = 32'(r_fall_en);
                OFS_STAT: Data_out = 32'(r_status);
                OFS_SET:  Data_out = 32'h0;
                OFS_CLR:  Data_out = 32'h0;
                default:  Data_out = 32'h0;
            endcase
        end
    end

    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign irq      = r_irq;

endmodule

// File: doc/gpio_irq_port.md
GPIO_IRQ_PORT -- requirements
Module: gpio_irq_port

Interface
REQ-001 Parameter WIDTH, default 8, pin count per port, legal range 1..32.
REQ-002 Parameter BASE_ADR, default 32'h0000_0100, byte base of 32-byte register window, 32-byte aligned.
REQ-003 Parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..3.
REQ-004 Port clk  input  1  single clock, all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port Adr_in  input  32  byte address from peripheral decode.
REQ-007 Port WE  input  1  write strobe, qualified by address hit.
REQ-008 Port Data_in  input  32  write data.
REQ-009 Port Data_out  output  32  read data, combinational from Adr_in and registered state.
REQ-010 Port gpio_in  input  WIDTH  asynchronous pin inputs (switches).
REQ-011 Port gpio_out  output  WIDTH  output pin values (LEDs), equal to OUT register.
REQ-012 Port gpio_oe  output  WIDTH  per-pin output enable, equal to DIR register.
REQ-013 Port irq  output  1  level interrupt, OR of (STATUS) bits, driven from flops only.

Function
REQ-014 Hit SHALL be Adr_in[31:5]==BASE_ADR[31:5]; offset = Adr_in[4:2]; Adr_in[1:0] ignored.
REQ-015 Map: 0 OUT (RW), 1 DIR (RW, 1=output), 2 IN (RO), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 STATUS (RW1C), 6 OUT_SET (WO), 7 OUT_CLR (WO).
REQ-016 Writes SHALL take effect at the rising clk edge where WE=1 and hit=1; only bits [WIDTH-1:0] stored.
REQ-017 Reads SHALL return the register zero-extended to 32 bits; offsets 6/7 and non-hit addresses read 32'h0.
REQ-018 OUT_SET write: OUT <= OUT | Data_in; OUT_CLR write: OUT <= OUT & ~Data_in.
REQ-019 Each gpio_in bit SHALL pass SYNC_STAGES flops, then one history flop; IN reads the last sync stage.
REQ-020 Rise event on bit i: sync=1, history=0; fall event: sync=0, history=1.
REQ-021 STATUS[i] SHALL set on the edge after (rise&RISE_EN[i]) | (fall&FALL_EN[i]); pin-to-STATUS latency SYNC_STAGES+1 cycles.
REQ-022 STATUS write: bits with Data_in=1 clear, others hold.
REQ-023 Same-cycle event and W1C on one bit: set wins, bit stays 1.
REQ-024 Events on pins with DIR=1 SHALL still be detected (loop-back readable).
REQ-025 irq SHALL rise the cycle STATUS becomes nonzero, fall the cycle after the last bit clears.
REQ-026 Enabling RISE_EN/FALL_EN SHALL NOT set STATUS for a pin already at steady level.

Reset
REQ-027 rst=0 SHALL asynchronously clear OUT, DIR, RISE_EN, FALL_EN, STATUS, sync and history flops to 0.
REQ-028 During and after reset: gpio_out=0, gpio_oe=0, irq=0, Data_out=0 for IN until synchronized.
REQ-029 Pin held 1 across reset release SHALL produce one rise event only if RISE_EN set before it reaches history; reset mid-pulse discards pending events.

Structure
REQ-030 Package gpio_irq_pkg SHALL hold offset constants (OFS_OUT..OFS_CLR) and the 32-byte window size.
REQ-031 One sub-module gpio_sync_edge SHALL implement per-vector synchronizer, history flop and rise/fall outputs.
REQ-032 Top SHALL contain decode, register file, read mux, STATUS logic; target 150-300 RTL lines.

Verification
REQ-033 Reset: assert rst=0 mid-run with OUT=8'hFF -> gpio_out=0, gpio_oe=0, irq=0 immediately, no clk needed.
REQ-034 Write OUT=8'hA5, OUT_SET=8'h0A, OUT_CLR=8'h81 -> gpio_out 8'hA5, 8'hAF, 8'h2E; read offset 0 returns 32'h0000_002E.
REQ-035 RISE_EN=8'h01, gpio_in 0->1 on bit0 -> STATUS=8'h01 and irq=1 exactly 3 cycles later (SYNC_STAGES=2); no FALL_EN -> no set on 1->0.
REQ-036 STATUS=8'h03, write 8'h01 to STATUS same cycle as new bit0 event -> STATUS stays 8'h03; next write 8'h03 -> 0, irq=0 next cycle.
REQ-037 WIDTH=32, BASE_ADR=32'h0000_0200: access 32'h0000_0100 -> no write, read 0; read 32'h0000_0208 with pins 32'hDEAD_BEEF -> DEAD_BEEF after sync.
REQ-038 Read offset 6, 7 and Adr_in[1:0]=2'b11 on offset 1 -> 0, 0, DIR value respectively.
